// File: rtl/acondicionar_botones.sv
// Button conditioning: synchronize, debounce, optional hold-to-repeat, and
// serialize press events into single-cycle move pulses in fixed priority order.
module acondicionar_botones #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_CYCLES   = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_arriba,
  input  logic       btn_abajo,
  input  logic       btn_derecha,
  input  logic       btn_izquierda,
  output logic       arriba,
  output logic       abajo,
  output logic       derecha,
  output logic       izquierda,
  output logic [3:0] nivel
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = (REPEAT_CYCLES < 2) ? 2 : $clog2(REPEAT_CYCLES + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0] raw;
  logic [3:0] level_vec;
  logic [3:0] rise_vec;
  logic [3:0] rep_vec;
  logic [3:0] pending_q, pending_d;
  logic [3:0] pulse_q, pulse_d;

  assign raw = {btn_arriba, btn_abajo, btn_derecha, btn_izquierda};

  for (genvar gi = 0; gi < 4; gi++) begin : g_btn
    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Level flips on the edge where the mismatch count would reach DEBOUNCE_CYCLES.
    always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
        if (cnt_q == DEB_LAST) begin
          level_d = ~level_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        level_q <= 1'b0;
        cnt_q   <= '0;
      end else begin
        sync1_q <= raw[gi];
        sync2_q <= sync1_q;
        level_q <= level_d;
        cnt_q   <= cnt_d;
      end
    end

    assign level_vec[gi] = level_q;
    assign rise_vec[gi]  = level_d & ~level_q;

    if (REPEAT_CYCLES != 0) begin : g_rep
      localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
      logic [RW-1:0] rep_q, rep_d;
      logic          hit;

      // Counting only while the level stays high keeps a release edge from firing a repeat.
      always_comb begin
        rep_d = '0;
        hit   = 1'b0;
        if (level_q && level_d) begin
          if (rep_q == REP_LAST) begin
            hit = 1'b1;
          end else begin
            rep_d = rep_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          rep_q <= '0;
        end else begin
          rep_q <= rep_d;
        end
      end

      assign rep_vec[gi] = hit;
    end else begin : g_norep
      assign rep_vec[gi] = 1'b0;
    end
  end

  always_comb begin
    pulse_d = 4'b0000;
    if (pending_q[3]) begin
      pulse_d = 4'b1000;
    end else if (pending_q[2]) begin
      pulse_d = 4'b0100;
    end else if (pending_q[1]) begin
      pulse_d = 4'b0010;
    end else if (pending_q[0]) begin
      pulse_d = 4'b0001;
    end
    // New events are OR'd in after the grant clear, so a same-edge set survives.
    pending_d = (pending_q & ~pulse_d) | rise_vec | rep_vec;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q <= 4'b0000;
      pulse_q   <= 4'b0000;
    end else begin
      pending_q <= pending_d;
      pulse_q   <= pulse_d;
    end
  end

  assign {arriba, abajo, derecha, izquierda} = pulse_q;
  assign nivel = level_vec;

endmodule

// File: doc/acondicionar_botones.md
ACONDICIONAR_BOTONES -- requirements
Module: acondicionar_botones

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive cycles a synchronized input must differ from its debounced level before that level changes; legal range 2..65535.
REQ-002 SHALL have parameter REPEAT_CYCLES, default 0: hold-to-repeat period in cycles; 0 disables repeat; legal range 0 or 2..65535.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  one clock; reset is asynchronous and active-low.
REQ-005 SHALL have ports btn_arriba, btn_abajo, btn_derecha, btn_izquierda  input  1 each  raw asynchronous push-buttons, 1 = pressed.
REQ-006 SHALL have ports arriba, abajo, derecha, izquierda  output  1 each  registered single-cycle move pulses feeding the downstream moverse inputs of the same names.
REQ-007 SHALL have port nivel  output  4  debounced levels {arriba, abajo, derecha, izquierda}, bit 3 = arriba.

Function
REQ-008 SHALL pass each raw button through a 2-flop synchronizer before any other logic.
REQ-009 SHALL keep, per button, a debounced level and a counter of width $clog2(DEBOUNCE_CYCLES+1); counter increments each cycle the synchronized value differs from the level, clears on any cycle it matches.
REQ-010 SHALL toggle the level and clear the counter on the edge where the counter would reach DEBOUNCE_CYCLES; bounces shorter than DEBOUNCE_CYCLES cycles SHALL produce no level change and no pulse.
REQ-011 SHALL set a per-button pending bit on each 0->1 transition of the debounced level.
REQ-012 With REPEAT_CYCLES != 0, SHALL count cycles while a debounced level stays 1, set that button's pending bit and restart the count each time REPEAT_CYCLES is reached; a 1->0 level transition SHALL clear the repeat count.
REQ-013 SHALL issue at most one output pulse per cycle: the highest-priority pending bit (arriba > abajo > derecha > izquierda) drives its output high for exactly one cycle and is cleared on that edge.
REQ-014 Lower-priority pending bits SHALL be held and issued on subsequent cycles in priority order; no event is dropped.
REQ-015 If a pending bit is set and cleared on the same edge, set SHALL win (second pulse follows).
REQ-016 A pulse SHALL appear exactly DEBOUNCE_CYCLES+3 edges after the first edge sampling a clean raw rise, when no higher-priority bit is pending.
REQ-017 Button release SHALL produce no pulse; nivel SHALL follow the debounced levels with no further delay.

Reset
REQ-018 While reset is low: synchronizers, levels, counters, repeat counts and pending bits SHALL be 0; arriba, abajo, derecha, izquierda and nivel SHALL read 0 immediately (asynchronously).
REQ-019 Reset asserted mid-debounce or with pending bits SHALL discard them; no pulse SHALL follow deassertion from pre-reset activity.
REQ-020 A button held across reset deassertion SHALL be treated as a new press: one pulse after DEBOUNCE_CYCLES+3 edges.

Verification
REQ-021 DEBOUNCE_CYCLES=4, REPEAT_CYCLES=0: btn_arriba held 20 cycles -> arriba high exactly one cycle at edge 7, nivel=4'b1000 from edge 6, no pulse on release.
REQ-022 DEBOUNCE_CYCLES=4: btn_derecha toggling high 3 cycles / low 1 cycle, 5 times, then low -> no pulse, nivel stays 0.
REQ-023 DEBOUNCE_CYCLES=4: all four buttons rise same cycle and held -> pulses arriba, abajo, derecha, izquierda on edges 7, 8, 9, 10, one each.
REQ-024 DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8: btn_abajo held 40 cycles -> abajo pulses at edges 7, 15, 23, 31, 39, then stop on release.
REQ-025 DEBOUNCE_CYCLES=4: reset pulled low at edge 5 during btn_izquierda press, released at edge 9 with button still held -> all outputs 0 during reset, single izquierda pulse 7 edges after release.
